// File: rtl/par8_pkg.sv
// rtl/par8_pkg.sv - shared constants and state encoding for the 8-bit parallel host bus
package par8_pkg;

  localparam int PAR8_W          = 8;
  localparam int CLK_HALF_DEF    = 8;
  localparam int TURN_CYCLES_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TURN  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/par8_master.sv
// rtl/par8_master.sv - host-side master for the 8-bit parallel bus (single-byte read/write with turnaround)
// Optional byte counters: define PAR8_MASTER_STATS_EN.
module par8_master
  import par8_pkg::*;
#(
  parameter int CLK_HALF    = CLK_HALF_DEF,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rnw,
  input  logic [PAR8_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [PAR8_W-1:0] rsp_data,
  output logic              bus_clk,
  output logic              bus_rnw,
  output logic [PAR8_W-1:0] bus_data_out,
  output logic              bus_data_oe,
  input  logic [PAR8_W-1:0] bus_data_in
`ifdef PAR8_MASTER_STATS_EN
  ,
  output logic [31:0]       stat_wr_bytes,
  output logic [31:0]       stat_rd_bytes
`endif
);

  localparam int CNT_W = $clog2(max_int(CLK_HALF, TURN_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_HALF - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_rnw;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [PAR8_W-1:0] r_rsp_data;
  logic              r_bus_clk;
  logic              r_bus_rnw;
  logic              r_bus_oe;
  logic [PAR8_W-1:0] r_bus_dout;
  logic [PAR8_W-1:0] r_din;
`ifdef PAR8_MASTER_STATS_EN
  logic [31:0]       r_stat_wr;
  logic [31:0]       r_stat_rd;
`endif

  logic w_accept;
  logic w_cnt_done;

  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_last_rnw  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_bus_clk   <= 1'b0;
      r_bus_rnw   <= 1'b0;
      r_bus_oe    <= 1'b0;
      r_bus_dout  <= '0;
      r_din       <= '0;
`ifdef PAR8_MASTER_STATS_EN
      r_stat_wr   <= '0;
      r_stat_rd   <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_din       <= bus_data_in;
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_last_rnw  <= cmd_rnw;
            if (!cmd_rnw) r_bus_dout <= cmd_data;
            // Direction change: release both oe and rnw before the new direction is driven.
            if (cmd_rnw != r_last_rnw) begin
              r_state   <= ST_TURN;
              r_cnt     <= TURN_LOAD;
              r_bus_oe  <= 1'b0;
              r_bus_rnw <= 1'b0;
            end else begin
              r_state   <= ST_SETUP;
              r_cnt     <= HALF_LOAD;
              r_bus_rnw <= cmd_rnw;
              r_bus_oe  <= ~cmd_rnw;
            end
          end
        end
        ST_TURN: begin
          if (w_cnt_done) begin
            r_state   <= ST_SETUP;
            r_cnt     <= HALF_LOAD;
            r_bus_rnw <= r_last_rnw;
            r_bus_oe  <= ~r_last_rnw;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_state   <= ST_HIGH;
            r_cnt     <= HALF_LOAD;
            r_bus_clk <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_cnt_done) begin
            r_state   <= ST_HOLD;
            r_cnt     <= HALF_LOAD;
            r_bus_clk <= 1'b0;
            if (r_last_rnw) begin
              r_rsp_data  <= r_din;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_cnt_done) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
`ifdef PAR8_MASTER_STATS_EN
            if (r_last_rnw) r_stat_rd <= r_stat_rd + 32'd1;
            else            r_stat_wr <= r_stat_wr + 32'd1;
`endif
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign bus_clk      = r_bus_clk;
  assign bus_rnw      = r_bus_rnw;
  assign bus_data_oe  = r_bus_oe;
  assign bus_data_out = r_bus_dout;
`ifdef PAR8_MASTER_STATS_EN
  assign stat_wr_bytes = r_stat_wr;
  assign stat_rd_bytes = r_stat_rd;
`endif

endmodule

// File: tb/tb_par8_master.sv
// tb/tb_par8_master.sv - randomized scoreboard bench for par8_master against a cycle-offset reference model
module tb_par8_master;

  localparam int CH = 8;
  localparam int TC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rnw = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       bus_clk;
  logic       bus_rnw;
  logic [7:0] bus_data_out;
  logic       bus_data_oe;
  logic [7:0] bus_data_in;
  logic [7:0] slave_byte = 8'h00;
`ifdef PAR8_MASTER_STATS_EN
  logic [31:0] stat_wr_bytes;
  logic [31:0] stat_rd_bytes;
`endif

  always #5 clk = ~clk;

  // Slave model: presents its byte only while the master asks for a read.
  assign bus_data_in = bus_rnw ? slave_byte : 8'hEE;

  par8_master dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rnw      (cmd_rnw),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .bus_clk      (bus_clk),
    .bus_rnw      (bus_rnw),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .bus_data_in  (bus_data_in)
`ifdef PAR8_MASTER_STATS_EN
    ,
    .stat_wr_bytes(stat_wr_bytes),
    .stat_rd_bytes(stat_rd_bytes)
`endif
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;

  // Reference model of the most recently accepted command.
  bit         have_cmd = 1'b0;
  int         m_T = 0;
  bit         m_turn = 1'b0;
  bit         m_dir = 1'b0;
  logic [7:0] m_byte = 8'h00;
  bit         m_last = 1'b0;
  int         n_wr = 0;
  int         n_rd = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, edge_n + 1);
    end
  endtask

  // Monitor: cycle c is the interval following edge c-1.
  always @(negedge clk) begin
    int   c;
    int   off;
    int   soff;
    logic e_clk;
    logic e_rnw;
    logic e_oe;
    logic e_rdy;
    rsp_t r;
    c = edge_n + 1;
    chk("oe_and_rnw", longint'(bus_data_oe & bus_rnw), 0);
    if (have_cmd) begin
      off   = c - m_T;
      soff  = 1 + (m_turn ? TC : 0);
      e_clk = 1'b0;
      e_rdy = 1'b0;
      e_rnw = m_dir;
      e_oe  = !m_dir;
      if (off < soff) begin
        e_rnw = 1'b0;
        e_oe  = 1'b0;
      end else if (off >= soff + CH && off < soff + 2 * CH) begin
        e_clk = 1'b1;
      end else if (off >= soff + 3 * CH) begin
        e_rdy = 1'b1;
      end
      chk("bus_clk", longint'(bus_clk), longint'(e_clk));
      chk("bus_rnw", longint'(bus_rnw), longint'(e_rnw));
      chk("bus_data_oe", longint'(bus_data_oe), longint'(e_oe));
      chk("cmd_ready", longint'(cmd_ready), longint'(e_rdy));
      if (e_oe) chk("bus_data_out", longint'(bus_data_out), longint'(m_byte));
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        r = sb.pop_front();
        chk("rsp_cycle", longint'(c), longint'(r.cyc));
        chk("rsp_data", longint'(rsp_data), longint'(r.d));
      end
    end else if (sb.size() > 0 && sb[0].cyc < c) begin
      r = sb.pop_front();
      chk("rsp_missing", longint'(c), longint'(r.cyc));
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit rnw, input logic [7:0] d);
    int   w;
    int   t;
    rsp_t r;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 0, 1);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_data  = rnw ? 8'($urandom) : d;
    if (rnw) slave_byte = d;
    t = edge_n + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_rnw   = 1'($urandom);
    cmd_data  = 8'($urandom);
    m_turn    = (rnw != m_last);
    m_T       = t;
    m_dir     = rnw;
    m_byte    = d;
    m_last    = rnw;
    have_cmd  = 1'b1;
    if (rnw) begin
      r.cyc = t + 1 + (m_turn ? TC : 0) + 2 * CH;
      r.d   = d;
      sb.push_back(r);
      n_rd++;
    end else begin
      n_wr++;
    end
    @(negedge clk);
  endtask

  initial begin
    int s;
    int target;
    int w;
    repeat (3) @(negedge clk);
    chk("rst_bus_clk", longint'(bus_clk), 0);
    chk("rst_bus_rnw", longint'(bus_rnw), 0);
    chk("rst_bus_oe", longint'(bus_data_oe), 0);
    chk("rst_bus_dout", longint'(bus_data_out), 0);
    chk("rst_rsp_valid", longint'(rsp_valid), 0);
    chk("rst_rsp_data", longint'(rsp_data), 0);
    chk("rst_cmd_ready", longint'(cmd_ready), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", longint'(cmd_ready), 1);

    issue(1'b0, 8'hA5);
    issue(1'b1, 8'h3C);
    issue(1'b1, 8'h01);
    issue(1'b1, 8'h02);
    issue(1'b1, 8'h03);
    issue(1'b0, 8'h96);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Abort a read in its third HIGH cycle.
    issue(1'b1, 8'h5A);
    s = m_T + 1 + (m_turn ? TC : 0);
    target = s + CH + 2;
    while (edge_n + 1 < target) @(negedge clk);
    chk("abort_pre_clk", longint'(bus_clk), 1);
    have_cmd = 1'b0;
    sb.delete();
    reset = 1'b1;
    @(negedge clk);
    n_wr = 0;
    n_rd = 0;
    chk("abort_bus_clk", longint'(bus_clk), 0);
    chk("abort_bus_oe", longint'(bus_data_oe), 0);
    chk("abort_bus_rnw", longint'(bus_rnw), 0);
    chk("abort_rsp_valid", longint'(rsp_valid), 0);
    reset = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    chk("abort_ready", longint'(cmd_ready), 1);

    issue(1'b0, 8'hC3);
    issue(1'b1, 8'h7E);
    issue(1'b0, 8'h11);

    w = 0;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("final_timeout", 0, 1);
    repeat (4) @(negedge clk);
    chk("sb_empty", longint'(sb.size()), 0);
`ifdef PAR8_MASTER_STATS_EN
    chk("stat_wr", longint'(stat_wr_bytes), longint'(n_wr));
    chk("stat_rd", longint'(stat_rd_bytes), longint'(n_rd));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
